// File: rtl/outer_seq.sv
// outer_seq: token sequencer for one terminal-input line.
// Drives finder/atoi/inner-interpreter/stack blocks and compiles into the dictionary.
module outer_seq #(
    parameter int MSZ = 8,
    parameter int DSZ = 32,
    parameter int ASZ = 17,
    parameter logic [ASZ-1:0] TIB = '0,
    parameter logic [MSZ-1:0] LIT_OP = 'h0c,
    parameter logic [ASZ-1:0] HERE_MAX = {ASZ{1'b1}}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    input  logic           compile,
    input  logic [ASZ-1:0] here0,
    output logic           find_go,
    input  logic           find_done,
    input  logic           find_hit,
    input  logic           find_imm,
    input  logic           find_eot,
    input  logic [MSZ-1:0] find_op,
    input  logic [ASZ-1:0] find_tib,
    output logic           a2i_go,
    input  logic           a2i_done,
    input  logic           a2i_ok,
    input  logic [DSZ-1:0] a2i_val,
    input  logic [ASZ-1:0] a2i_tib,
    output logic           exe_go,
    output logic [MSZ-1:0] exe_op,
    input  logic           exe_done,
    output logic           ss_push,
    output logic [DSZ-1:0] ss_val,
    input  logic           ss_full,
    output logic           mw_we,
    output logic [ASZ-1:0] mw_ai,
    output logic [MSZ-1:0] mw_vi,
    output logic [ASZ-1:0] tib,
    output logic [ASZ-1:0] here,
    output logic           bsy,
    output logic           done,
    output logic           err,
    output logic [1:0]     err_code
);

    localparam int NB = DSZ / MSZ;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [ASZ:0] NBW = (ASZ + 1)'(NB);
    localparam logic [KW-1:0] KLAST = KW'(NB - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FND, S_EXE, S_CMW, S_A2I,
        S_PSH, S_LIT, S_NUM, S_ERR
    } state_t;

    state_t r_state, r_prev, w_next;

    logic [ASZ-1:0] r_tib, r_here;
    logic [MSZ-1:0] r_op;
    logic [DSZ-1:0] r_num;
    logic [KW-1:0]  r_k;
    logic           r_bsy, r_err;
    logic [1:0]     r_code, r_pcode;

    logic w_first, w_room_bad, w_cmw_bad, w_last;

    // A *_go pulse belongs to the first cycle after entering its state.
    assign w_first    = (r_state != r_prev);
    // Literal occupies here..here+NB; checked one bit wider so it cannot wrap.
    assign w_room_bad = ({1'b0, r_here} + NBW) > {1'b0, HERE_MAX};
    assign w_cmw_bad  = r_here > HERE_MAX;
    assign w_last     = (r_k == KLAST);

    assign exe_op   = r_op;
    assign ss_val   = r_num;
    assign mw_ai    = r_here;
    assign tib      = r_tib;
    assign here     = r_here;
    assign bsy      = r_bsy;
    assign err      = r_err;
    assign err_code = r_code;

    // State register, plus previous state for entry detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_prev  <= S_IDLE;
        end else begin
            r_state <= w_next;
            r_prev  <= r_state;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        w_next  = r_state;
        find_go = 1'b0;
        a2i_go  = 1'b0;
        exe_go  = 1'b0;
        ss_push = 1'b0;
        mw_we   = 1'b0;
        mw_vi   = r_op;
        done    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (go) w_next = S_FND;
            end
            S_FND: begin
                find_go = w_first;
                if (find_done) begin
                    if (find_eot) begin
                        w_next = S_IDLE;
                        done   = 1'b1;
                    end else if (find_hit && compile && !find_imm) begin
                        w_next = S_CMW;
                    end else if (find_hit) begin
                        w_next = S_EXE;
                    end else begin
                        w_next = S_A2I;
                    end
                end
            end
            S_EXE: begin
                exe_go = w_first;
                if (exe_done) w_next = S_FND;
            end
            S_CMW: begin
                if (w_cmw_bad) begin
                    w_next = S_ERR;
                end else begin
                    mw_we  = 1'b1;
                    w_next = S_FND;
                end
            end
            S_A2I: begin
                a2i_go = w_first;
                if (a2i_done) begin
                    if (!a2i_ok)      w_next = S_ERR;
                    else if (compile) w_next = S_LIT;
                    else              w_next = S_PSH;
                end
            end
            S_PSH: begin
                if (ss_full) begin
                    w_next = S_ERR;
                end else begin
                    ss_push = 1'b1;
                    w_next  = S_FND;
                end
            end
            S_LIT: begin
                if (w_room_bad) begin
                    w_next = S_ERR;
                end else begin
                    mw_we  = 1'b1;
                    mw_vi  = LIT_OP;
                    w_next = S_NUM;
                end
            end
            S_NUM: begin
                mw_we = 1'b1;
                mw_vi = MSZ'(r_num >> (MSZ * r_k));
                if (w_last) w_next = S_FND;
            end
            S_ERR: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: parse pointer, dictionary top, latched op/number, error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tib   <= TIB;
            r_here  <= here0;
            r_op    <= '0;
            r_num   <= '0;
            r_k     <= '0;
            r_bsy   <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= 2'd0;
            r_pcode <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_tib  <= TIB;
                        r_err  <= 1'b0;
                        r_code <= 2'd0;
                        r_bsy  <= 1'b1;
                    end
                end
                S_FND: begin
                    if (find_done) begin
                        r_tib <= find_tib;
                        r_op  <= find_op;
                        if (find_eot) r_bsy <= 1'b0;
                    end
                end
                S_CMW: begin
                    if (w_cmw_bad) r_pcode <= 2'd3;
                    else           r_here  <= r_here + 1'b1;
                end
                S_A2I: begin
                    if (a2i_done) begin
                        r_tib <= a2i_tib;
                        r_num <= a2i_val;
                        if (!a2i_ok) r_pcode <= 2'd1;
                    end
                end
                S_PSH: begin
                    if (ss_full) r_pcode <= 2'd2;
                end
                S_LIT: begin
                    r_k <= '0;
                    if (w_room_bad) r_pcode <= 2'd3;
                    else            r_here  <= r_here + 1'b1;
                end
                S_NUM: begin
                    r_here <= r_here + 1'b1;
                    r_k    <= r_k + 1'b1;
                end
                S_ERR: begin
                    r_err  <= 1'b1;
                    r_code <= r_pcode;
                    r_tib  <= TIB;
                    r_bsy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
